// File: rtl/p2s_arbiter_pkg.sv
// Shared types and helpers for the p2s_arbiter block.
// FSM state enum, default widths and the per-requester word slicer.
package p2s_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_SIZE_DEF = 8;
  localparam int ID_W          = $clog2(N_REQ_DEF);

  // Widest request bus and word the slicer can handle.
  localparam int MAX_BUS = 1024;
  localparam int MAX_DW  = 64;

  // Index width that stays legal for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Word k of a packed bus of dw-bit words; caller truncates to dw.
  function automatic logic [MAX_DW-1:0] word_at(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        k,
    input int unsigned        dw
  );
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (k * dw);
    return sh[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/p2s_arbiter_rr.sv
// Round-robin pick: first set request at or after i_ptr, wrapping.
// Ports: i_req, i_ptr in; o_grant (one-hot), o_idx, o_any out.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % N_REQ;
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx      = ID_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/p2s_arbiter.sv
// Shares one parallel_to_serial converter among N_REQ requesters.
// Ports: clk, rst, req_i, data_i, ser_busy_i in; ack_o, done_o, err_o,
//   ser_start_o, ser_data_o, active_o, grant_id_o out.
module p2s_arbiter
  import p2s_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int GAP_CYCLES = 1,
  parameter int BUSY_TMO   = 4,
  localparam int IW = id_w(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_SIZE-1:0] data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           done_o,
  output logic                       err_o,
  output logic                       ser_start_o,
  output logic [DATA_SIZE-1:0]       ser_data_o,
  input  logic                       ser_busy_i,
  output logic                       active_o,
  output logic [IW-1:0]              grant_id_o
);

  localparam int TW = $clog2(BUSY_TMO + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic [DATA_SIZE-1:0] r_data;
  logic [N_REQ-1:0]     r_done;
  logic [TW-1:0]        r_tcnt;
  logic [GW-1:0]        r_gcnt;

  logic [N_REQ-1:0]     w_grant;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_err;
  logic [N_REQ-1:0]     w_own_oh;
  logic [DATA_SIZE-1:0] w_word;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (IW)
  ) u_rr (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_word = DATA_SIZE'(word_at(
    MAX_BUS'(data_i), int'(w_idx), DATA_SIZE));

  assign w_own_oh = N_REQ'(1) << r_owner;

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_any) w_next = S_LAUNCH;
      S_LAUNCH:
        w_next = S_WAIT_BUSY;
      S_WAIT_BUSY:
        if (ser_busy_i) begin
          w_next = S_WAIT_DONE;
        end else if (r_tcnt == TW'(BUSY_TMO - 1)) begin
          w_err  = 1'b1;
          w_next = S_GAP;
        end
      S_WAIT_DONE:
        if (!ser_busy_i) w_next = S_GAP;
      S_GAP:
        if (r_gcnt == GW'(GAP_CYCLES - 1)) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_data  <= '0;
      r_done  <= '0;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= '0;
      if (r_state == S_IDLE && w_any) begin
        r_data  <= w_word;
        r_owner <= w_idx;
        r_ptr   <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      // Counters run only while their state persists.
      if (r_state == S_WAIT_BUSY && w_next == S_WAIT_BUSY)
        r_tcnt <= r_tcnt + 1'b1;
      else
        r_tcnt <= '0;
      if (r_state == S_GAP && w_next == S_GAP)
        r_gcnt <= r_gcnt + 1'b1;
      else
        r_gcnt <= '0;
      // done lands in the first GAP cycle.
      if (r_state == S_WAIT_DONE && !ser_busy_i)
        r_done <= w_own_oh;
    end
  end

  assign ack_o       = (r_state == S_LAUNCH) ? w_own_oh : '0;
  assign ser_start_o = (r_state == S_LAUNCH);
  assign done_o      = r_done;
  assign err_o       = w_err;
  assign ser_data_o  = r_data;
  assign grant_id_o  = r_owner;
  assign active_o    = (r_state != S_IDLE);

  // Grant vector is implied by w_idx; kept for reuse of the arbiter.
  logic w_unused;
  assign w_unused = ^w_grant;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed testbench for p2s_arbiter with a behavioural
// MSB-first parallel_to_serial converter.
module tb_p2s_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data;
  logic [N-1:0]  ack, done;
  logic          err, start, busy, active;
  logic [DW-1:0] sdata;
  logic [1:0]    gid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p2s_arbiter #(
    .N_REQ(N), .DATA_SIZE(DW), .GAP_CYCLES(1), .BUSY_TMO(4)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .data_i(data),
    .ack_o(ack), .done_o(done), .err_o(err),
    .ser_start_o(start), .ser_data_o(sdata),
    .ser_busy_i(busy), .active_o(active), .grant_id_o(gid)
  );

  // Converter: loads on a rising start, busy for DW cycles.
  logic       kill;
  logic [7:0] cv_sh;
  logic [2:0] cv_cnt;
  logic       cv_busy, cv_sd, eff_start, sbit;

  assign eff_start = start & ~kill;
  assign busy      = cv_busy & ~kill;
  assign sbit      = cv_sh[7];

  always @(posedge clk) begin
    if (rst) begin
      cv_sh <= '0; cv_cnt <= '0; cv_busy <= 1'b0; cv_sd <= 1'b0;
    end else begin
      cv_sd <= eff_start;
      if (eff_start && !cv_sd && !cv_busy) begin
        cv_sh <= sdata; cv_cnt <= '0; cv_busy <= 1'b1;
      end else if (cv_busy) begin
        cv_sh <= {cv_sh[6:0], 1'b0};
        if (cv_cnt == 3'd7) cv_busy <= 1'b0;
        else cv_cnt <= cv_cnt + 3'd1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; kill = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && active; i++) tick;
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++; $display("FAIL drain: active=%b expected 0", active);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '1; data = '1; kill = 1'b0;
    tick; tick; tick;
    n_checks++;
    if ({ack, done, err, start, active} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 0",
               {ack, done, err, start, active});
    end
    n_checks++;
    if (sdata !== 8'h00 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h gid=%0d expected 00/0", sdata, gid);
    end
    req = '0; rst = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] exp;
    exp = 8'hA5;
    do_reset;
    data = '0; data[7:0] = 8'hA5; req = 4'b0001;
    tick;
    n_checks++;
    if (ack !== 4'b0001 || start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_c1: ack=%b start=%b expected 0001/1", ack, start);
    end
    n_checks++;
    if (sdata !== 8'hA5 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL single_word: data=%h gid=%0d expected a5/0", sdata, gid);
    end
    req = '0;
    for (int c = 2; c <= 9; c++) begin
      tick;
      n_checks++;
      if (busy !== 1'b1 || sbit !== exp[9-c] || done !== 4'b0) begin
        n_fail++;
        $display("FAIL single_bit c%0d: busy=%b bit=%b done=%b expected 1/%b/0000",
                 c, busy, sbit, done, exp[9-c]);
      end
    end
    tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL single_c10: busy=%b done=%b expected 0/0000", busy, done);
    end
    tick;
    n_checks++;
    if (done !== 4'b0001) begin
      n_fail++; $display("FAIL single_done: done=%b expected 0001", done);
    end
    tick;
    n_checks++;
    if (active !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL single_c12: active=%b done=%b expected 0/0000", active, done);
    end
  endtask

  task automatic test_contention;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] asmb;
    int nack, ndone, last_done;
    nack = 0; ndone = 0; last_done = -1; asmb = '0;
    do_reset;
    data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
    for (int cyc = 1; cyc <= 100 && ndone < 5; cyc++) begin
      tick;
      if (busy) asmb = {asmb[6:0], sbit};
      if (ack !== 4'b0 && nack < 5) begin
        n_checks++;
        if (gid !== 2'(exp_ord[nack]) || ack !== (4'b1 << exp_ord[nack])
            || sdata !== words[exp_ord[nack]]) begin
          n_fail++;
          $display("FAIL cont_grant%0d: gid=%0d ack=%b data=%h expected %0d",
                   nack, gid, ack, sdata, exp_ord[nack]);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done !== 2) begin
            n_fail++;
            $display("FAIL cont_gap: %0d cycles done->start expected 2",
                     cyc - last_done);
          end
        end
        asmb = '0;
        nack++;
        if (nack == 5) req = '0;
      end
      if (done !== 4'b0 && ndone < 5) begin
        n_checks++;
        if (done !== (4'b1 << exp_ord[ndone]) || asmb !== words[exp_ord[ndone]]) begin
          n_fail++;
          $display("FAIL cont_done%0d: done=%b stream=%h expected owner %0d",
                   ndone, done, asmb, exp_ord[ndone]);
        end
        last_done = cyc;
        ndone++;
      end
    end
    n_checks++;
    if (ndone !== 5) begin
      n_fail++; $display("FAIL cont_count: %0d dones expected 5", ndone);
    end
    req = '0;
    drain;
  endtask

  task automatic test_fairness;
    int exp_ord [3] = '{0, 2, 0};
    int nack, since;
    nack = 0; since = 0;
    do_reset;
    data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b0001;
    for (int cyc = 1; cyc <= 60 && nack < 3; cyc++) begin
      tick;
      since++;
      if (ack !== 4'b0) begin
        n_checks++;
        if (gid !== 2'(exp_ord[nack])) begin
          n_fail++;
          $display("FAIL fair_grant%0d: gid=%0d expected %0d",
                   nack, gid, exp_ord[nack]);
        end
        if (gid == 2'd2) req[2] = 1'b0;
        nack++;
        since = 0;
      end
      if (nack == 1 && since == 3) req[2] = 1'b1;
    end
    n_checks++;
    if (nack !== 3) begin
      n_fail++; $display("FAIL fair_count: %0d grants expected 3", nack);
    end
    req = '0;
    drain;
  endtask

  task automatic test_timeout;
    int dseen;
    dseen = 0;
    do_reset;
    kill = 1'b1;
    data = '0; data[7:0] = 8'h77; req = 4'b0001;
    tick;
    n_checks++;
    if (start !== 1'b1) begin
      n_fail++; $display("FAIL tmo_start: start=%b expected 1", start);
    end
    req = '0;
    for (int c = 2; c <= 8; c++) begin
      tick;
      if (done !== 4'b0) dseen++;
      n_checks++;
      if (err !== (c == 5)) begin
        n_fail++;
        $display("FAIL tmo_err c%0d: err=%b expected %b", c, err, c == 5);
      end
      if (c == 6 || c == 7) begin
        n_checks++;
        if (active !== (c == 6)) begin
          n_fail++;
          $display("FAIL tmo_active c%0d: active=%b expected %b",
                   c, active, c == 6);
        end
      end
    end
    n_checks++;
    if (dseen !== 0) begin
      n_fail++; $display("FAIL tmo_done: %0d done pulses expected 0", dseen);
    end
    kill = 1'b0;
  endtask

  task automatic test_reset_mid;
    int dseen;
    dseen = 0;
    do_reset;
    data = '0; data[23:16] = 8'h3C; req = 4'b0100;
    tick;
    n_checks++;
    if (gid !== 2'd2) begin
      n_fail++; $display("FAIL rmid_grant: gid=%0d expected 2", gid);
    end
    req = '0;
    tick; tick; tick; tick;
    n_checks++;
    if (active !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: active=%b busy=%b expected 1/1", active, busy);
    end
    rst = 1'b1;
    tick;
    n_checks++;
    if ({ack, done, err, start, active} !== 11'd0 || sdata !== 8'h00
        || gid !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear: ctl=%b data=%h gid=%0d busy=%b expected 0",
               {ack, done, err, start, active}, sdata, gid, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done !== 4'b0) dseen++;
    end
    n_checks++;
    if (dseen !== 0) begin
      n_fail++; $display("FAIL rmid_nodone: %0d done pulses expected 0", dseen);
    end
    data[7:0] = 8'h5A; data[31:24] = 8'hC3; req = 4'b1001;
    tick;
    n_checks++;
    if (gid !== 2'd0 || sdata !== 8'h5A || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_ptr: gid=%0d data=%h ack=%b expected 0/5a/0001",
               gid, sdata, ack);
    end
    req = '0;
    for (int i = 0; i < 10; i++) tick;
    n_checks++;
    if (done !== 4'b0001) begin
      n_fail++; $display("FAIL rmid_done: done=%b expected 0001", done);
    end
    drain;
  endtask

  task automatic test_dropped;
    int nack, nack1, ndone;
    nack = 0; nack1 = 0; ndone = 0;
    do_reset;
    data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b0001;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick;
      if (cyc == 1) req = '0;
      if (cyc == 4) req = 4'b0010;
      if (cyc == 5) req = '0;
      if (ack !== 4'b0) nack++;
      if (ack[1] === 1'b1) nack1++;
      if (done !== 4'b0) ndone++;
    end
    n_checks++;
    if (nack !== 1 || nack1 !== 0 || ndone !== 1) begin
      n_fail++;
      $display("FAIL dropped: acks=%0d ack1=%0d dones=%0d expected 1/0/1",
               nack, nack1, ndone);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; data = '0; kill = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_fairness;
    test_timeout;
    test_reset_mid;
    test_dropped;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
